// File: rtl/yc_pkg.sv
// Shared types and constants for the yellow-cell configuration sequencer.
// Holds the FSM state set, the array value encodings and the 3-bit cell config codes.
package yc_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StWait,
    StSetup,
    StHigh,
    StSamp,
    StPost,
    StRun
  } yc_state_e;

  typedef enum logic [1:0] {
    VEmpty = 2'b00,
    V0     = 2'b01,
    V1     = 2'b10
  } yc_val_e;

  localparam logic [2:0] CfgEmpty = 3'd0;
  localparam logic [2:0] CfgPlus  = 3'd1;
  localparam logic [2:0] CfgMinus = 3'd2;
  localparam logic [2:0] CfgBar   = 3'd3;
  localparam logic [2:0] CfgOne   = 3'd4;
  localparam logic [2:0] CfgZero  = 3'd5;
  localparam logic [2:0] CfgY     = 3'd6;
  localparam logic [2:0] CfgN     = 3'd7;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/yc_config_sequencer_if.sv
// Host beat port plus array-facing strobe/data lines of the configuration sequencer.
// The sequencer uses the slave modport; the host/array environment uses master.
interface yc_config_sequencer_if #(
  parameter int unsigned COLS = 8
) ();

  logic            start;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [COLS-1:0] cfg_data;
  logic            rd_valid;
  logic [COLS-1:0] rd_data;
  logic            busy;
  logic            done;
  logic            arr_reset;
  logic            confclk;
  logic [COLS-1:0] cbit;
  logic [COLS-1:0] cbitout_i;

  modport slave (
    input  start, cfg_valid, cfg_data, cbitout_i,
    output cfg_ready, rd_valid, rd_data, busy, done, arr_reset, confclk, cbit
  );

  modport master (
    output start, cfg_valid, cfg_data, cbitout_i,
    input  cfg_ready, rd_valid, rd_data, busy, done, arr_reset, confclk, cbit
  );

endinterface

// File: rtl/yc_phase_timer.sv
// Loadable down-counter that saturates at zero; one instance times every phase of the FSM.
module yc_phase_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/yc_config_sequencer.sv
// Shifts host beats into the column config chains of a yellow-cell array with a timed confclk,
// reads back each chain's cbitout, and releases array reset once loading has settled.
module yc_config_sequencer #(
  parameter int unsigned COLS       = 8,
  parameter int unsigned ROWS       = 8,
  parameter int unsigned CBITS      = 3,
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 4
) (
  input logic                 clk,
  input logic                 reset_n,
  yc_config_sequencer_if.slave bus
);
  import yc_pkg::*;

  localparam int unsigned Beats = CBITS * ROWS;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned TmrW  = $clog2(max3(SETUP_CYC, PULSE_CYC, SETTLE_CYC) + 1);

  // Timer is loaded with N-1 on phase entry so each phase lasts exactly N cycles.
  localparam logic [TmrW-1:0]  SettleLd = TmrW'(SETTLE_CYC - 1);
  localparam logic [TmrW-1:0]  SetupLd  = TmrW'(SETUP_CYC - 1);
  localparam logic [TmrW-1:0]  PulseLd  = TmrW'(PULSE_CYC - 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  yc_state_e        r_state, w_state_d;
  logic [BeatW-1:0] r_beat_cnt, w_beat_cnt_d;
  logic [COLS-1:0]  r_cbit, w_cbit_d;
  logic [COLS-1:0]  r_rd_data, w_rd_data_d;
  logic             w_rd_valid_d;
  logic             r_rd_valid, r_cfg_ready, r_busy, r_done, r_arr_reset, r_confclk;
  logic             w_tmr_load, w_tmr_zero;
  logic [TmrW-1:0]  w_tmr_value;

  yc_phase_timer #(
    .WIDTH(TmrW)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .i_load (w_tmr_load),
    .i_value(w_tmr_value),
    .o_zero (w_tmr_zero)
  );

  always_comb begin
    w_state_d    = r_state;
    w_beat_cnt_d = r_beat_cnt;
    w_cbit_d     = r_cbit;
    w_rd_data_d  = r_rd_data;
    w_rd_valid_d = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_value  = '0;
    unique case (r_state)
      StIdle, StRun: begin
        if (bus.start) begin
          w_state_d    = StPre;
          w_beat_cnt_d = '0;
          w_tmr_load   = 1'b1;
          w_tmr_value  = SettleLd;
        end
      end
      StPre: if (w_tmr_zero) w_state_d = StWait;
      StWait: begin
        if (bus.cfg_valid && r_cfg_ready) begin
          w_cbit_d    = bus.cfg_data;
          w_state_d   = StSetup;
          w_tmr_load  = 1'b1;
          w_tmr_value = SetupLd;
        end
      end
      StSetup: begin
        if (w_tmr_zero) begin
          w_state_d   = StHigh;
          w_tmr_load  = 1'b1;
          w_tmr_value = PulseLd;
        end
      end
      StHigh: if (w_tmr_zero) w_state_d = StSamp;
      StSamp: begin
        w_rd_data_d  = bus.cbitout_i;
        w_rd_valid_d = 1'b1;
        w_beat_cnt_d = r_beat_cnt + BeatW'(1);
        if (r_beat_cnt == LastBeat) begin
          w_state_d   = StPost;
          w_tmr_load  = 1'b1;
          w_tmr_value = SettleLd;
        end else begin
          w_state_d = StWait;
        end
      end
      StPost: if (w_tmr_zero) w_state_d = StRun;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_beat_cnt  <= '0;
      r_cbit      <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_arr_reset <= 1'b1;
      r_confclk   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_beat_cnt  <= w_beat_cnt_d;
      r_cbit      <= w_cbit_d;
      r_rd_data   <= w_rd_data_d;
      r_rd_valid  <= w_rd_valid_d;
      r_cfg_ready <= (w_state_d == StWait);
      r_busy      <= (w_state_d != StIdle) && (w_state_d != StRun);
      r_done      <= (w_state_d == StRun);
      r_arr_reset <= (w_state_d != StRun);
      r_confclk   <= (w_state_d == StHigh);
    end
  end

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.arr_reset = r_arr_reset;
  assign bus.confclk   = r_confclk;
  assign bus.cbit      = r_cbit;

endmodule

// File: tb/tb_yc_config_sequencer.sv
// Directed bench for yc_config_sequencer on a 2-row x 4-column array with a shift-chain model.
module tb_yc_config_sequencer;

  localparam int unsigned COLS  = 4;
  localparam int unsigned ROWS  = 2;
  localparam int unsigned CBITS = 3;
  localparam int          Beats = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  yc_config_sequencer_if #(.COLS(COLS)) bus ();

  yc_config_sequencer #(
    .COLS      (COLS),
    .ROWS      (ROWS),
    .CBITS     (CBITS),
    .SETUP_CYC (2),
    .PULSE_CYC (2),
    .SETTLE_CYC(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Array model: per column a 6-deep chain; cbitout is the bit most recently shifted out.
  logic [COLS-1:0] stage [Beats] = '{default: '0};
  logic [COLS-1:0] out_q = '0;
  always @(posedge bus.confclk) begin
    out_q <= stage[Beats-1];
    for (int i = Beats - 1; i > 0; i--) stage[i] <= stage[i-1];
    stage[0] <= bus.cbit;
  end
  assign bus.cbitout_i = out_q;

  int n_vec = 0;
  int n_err = 0;
  int pulse_cnt = 0, setup_bad = 0, high_bad = 0, cbit_bad = 0;
  int high_cnt = 0, stable_cnt = 0;
  logic prev_conf = 1'b0;
  logic [COLS-1:0] prev_cbit = '0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.confclk && !prev_conf) begin
        pulse_cnt++;
        if (stable_cnt < 2) setup_bad++;
        high_cnt = 0;
      end
      if (!bus.confclk && prev_conf && high_cnt != 2) high_bad++;
      if (bus.confclk) high_cnt++;
      if (bus.cbit != prev_cbit && (bus.confclk || prev_conf)) cbit_bad++;
    end else begin
      high_cnt = 0;
    end
    stable_cnt = (bus.cbit != prev_cbit) ? 1 : stable_cnt + 1;
    prev_conf  = bus.confclk;
    prev_cbit  = bus.cbit;
  end

  logic [COLS-1:0] hist [$];
  logic [COLS-1:0] exp_rd;
  logic [COLS-1:0] load3 [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [COLS-1:0] load5 [6] = '{4'h1, 4'hE, 4'h7, 4'h8, 4'h5, 4'hA};
  int pc;
  int hold_hi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!bus.cfg_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("cfg_ready_wait", 32'(bus.cfg_ready), 1);
  endtask

  task automatic wait_rd(input logic [COLS-1:0] exp);
    int t = 0;
    while (!bus.rd_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rd_valid_wait", 32'(bus.rd_valid), 1);
    chk("rd_data", 32'(bus.rd_data), 32'(exp));
  endtask

  function automatic logic [COLS-1:0] expect_out();
    return (hist.size() >= Beats) ? hist[hist.size()-Beats] : '0;
  endfunction

  task automatic send_beat(input logic [COLS-1:0] d);
    logic [COLS-1:0] e;
    wait_ready();
    e = expect_out();
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("cbit_load", 32'(bus.cbit), 32'(d));
    chk("ready_drop", 32'(bus.cfg_ready), 0);
    hist.push_back(d);
    wait_rd(e);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Called on the rd_valid cycle of the last beat: POST lasts 4 cycles, then RUN.
  task automatic finish_load();
    chk("post_done_low", 32'(bus.done), 0);
    repeat (3) @(negedge clk);
    chk("post_arr_reset", 32'(bus.arr_reset), 1);
    @(negedge clk);
    chk("run_arr_reset", 32'(bus.arr_reset), 0);
    chk("run_done", 32'(bus.done), 1);
    chk("run_busy", 32'(bus.busy), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;

    // 1: reset values, PRE settle time
    repeat (2) @(negedge clk);
    chk("rst_arr_reset", 32'(bus.arr_reset), 1);
    chk("rst_confclk", 32'(bus.confclk), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 0);
    reset_n = 1'b1;
    @(negedge clk);
    do_start();
    chk("pre_busy", 32'(bus.busy), 1);
    chk("pre_arr_reset", 32'(bus.arr_reset), 1);
    repeat (3) @(negedge clk);
    chk("pre_ready_early", 32'(bus.cfg_ready), 0);
    @(negedge clk);
    chk("pre_ready_on_time", 32'(bus.cfg_ready), 1);

    // 2: first load; the model chain starts empty so readback is zero
    pc = pulse_cnt;
    send_beat(4'hA);
    send_beat(4'h5);
    send_beat(4'hF);
    send_beat(4'h0);
    send_beat(4'h3);
    send_beat(4'hC);
    finish_load();
    chk("load1_pulses", 32'(pulse_cnt - pc), 6);

    // 3: reload zeros; readback replays the first load in order
    do_start();
    for (int i = 0; i < Beats; i++) send_beat(4'h0);
    finish_load();

    // 4: host stall in WAIT
    do_start();
    wait_ready();
    pc = pulse_cnt;
    hold_hi = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.confclk) hold_hi++;
    end
    chk("stall_confclk", 32'(hold_hi), 0);
    chk("stall_cbit", 32'(bus.cbit), 32'(hist[hist.size()-1]));
    chk("stall_pulses", 32'(pulse_cnt - pc), 0);
    chk("stall_ready", 32'(bus.cfg_ready), 1);
    send_beat(4'h9);

    // 5: cfg_valid during SETUP and start during HIGH are ignored
    wait_ready();
    exp_rd = expect_out();
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 4'h6;
    @(negedge clk);
    hist.push_back(4'h6);
    bus.cfg_data = 4'hE;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("setup_valid_ignored", 32'(bus.cbit), 32'h6);
    @(negedge clk);
    chk("high_reached", 32'(bus.confclk), 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_in_high_busy", 32'(bus.busy), 1);
    wait_rd(exp_rd);
    chk("cbit_after_ignored", 32'(bus.cbit), 32'h6);
    for (int i = 0; i < 4; i++) begin
      send_beat(load3[i]);
      if (i == 2) begin
        chk("beat5_not_done", 32'(bus.done), 0);
        chk("beat5_back_to_wait", 32'(bus.cfg_ready), 1);
      end
    end
    finish_load();
    chk("load3_pulses", 32'(pulse_cnt - pc), 6);

    // 6: reset during HIGH of beat 3, then a clean full load
    do_start();
    send_beat(4'hB);
    send_beat(4'hD);
    wait_ready();
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 4'h7;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    for (int t = 0; t < 10 && !bus.confclk; t++) @(negedge clk);
    chk("beat3_high", 32'(bus.confclk), 1);
    hist.push_back(4'h7);
    reset_n = 1'b0;
    #1;
    chk("async_confclk", 32'(bus.confclk), 0);
    chk("async_arr_reset", 32'(bus.arr_reset), 1);
    chk("async_busy", 32'(bus.busy), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", 32'(bus.cfg_ready), 0);
    chk("idle_done", 32'(bus.done), 0);
    do_start();
    pc = pulse_cnt;
    for (int i = 0; i < Beats; i++) send_beat(load5[i]);
    finish_load();
    chk("load5_pulses", 32'(pulse_cnt - pc), 6);

    chk("setup_violations", 32'(setup_bad), 0);
    chk("high_len_violations", 32'(high_bad), 0);
    chk("cbit_change_violations", 32'(cbit_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
